// File: rtl/int_controller.sv
// Prioritised five-line interrupt controller: synchronises and edge-detects requests,
// arbitrates at instruction boundaries and hands the vector over with req/ack/done.
module int_controller #(
   parameter int unsigned NUM_INT  = 5,
   parameter logic [7:0]  VEC_BASE = 8'hF8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_INT-1:0] irq,
   input  logic [7:0]         data,
   input  logic               mask_load,
   input  logic               ei,
   input  logic               di,
   input  logic               inst_boundary,
   input  logic               int_ack,
   input  logic               int_done,
   output logic               int_req,
   output logic [7:0]         int_vec,
   output logic [NUM_INT-1:0] int_lines,
   output logic [NUM_INT-1:0] pending,
   output logic               in_service
);

   localparam int unsigned IW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
   localparam logic [NUM_INT-1:0] ONE = {{(NUM_INT-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, PENDING, SERVICE} state_t;

   state_t             state, state_nxt;
   logic [NUM_INT-1:0] s1, s2, s3, mask, rise, eligible, clr;
   logic [NUM_INT-1:0] lines_nxt;
   logic [7:0]         vec_nxt;
   logic               req_nxt, ie, ie_nxt, win_found;
   logic [IW-1:0]      idx, idx_nxt, win_idx;

   generate
      if (NUM_INT < 8) begin : g_unused
         logic unused_data;
         assign unused_data = ^data[7:NUM_INT];
      end
   endgenerate

   assign rise       = s2 & ~s3;
   assign eligible   = pending & mask;
   assign in_service = (state == SERVICE);

   // Descending scan so the lowest eligible index is the last one written.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int unsigned i = NUM_INT; i > 0; i--) begin
         if (eligible[i-1]) begin
            win_idx   = IW'(i - 1);
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req_nxt   = int_req;
      vec_nxt   = int_vec;
      lines_nxt = int_lines;
      idx_nxt   = idx;
      clr       = '0;
      ie_nxt    = di ? 1'b0 : (ei ? 1'b1 : ie);
      case (state)
         IDLE: begin
            if (inst_boundary && ie && win_found) begin
               state_nxt = PENDING;
               idx_nxt   = win_idx;
               vec_nxt   = VEC_BASE | 8'(win_idx);
               lines_nxt = ONE << win_idx;
               req_nxt   = 1'b1;
            end
         end
         PENDING: begin
            if (int_ack) begin
               state_nxt = SERVICE;
               clr       = ONE << idx;
               ie_nxt    = 1'b0;
               req_nxt   = 1'b0;
            end
         end
         SERVICE: begin
            if (int_done) begin
               state_nxt = IDLE;
               ie_nxt    = 1'b1;
               lines_nxt = '0;
               vec_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         mask      <= '0;
         pending   <= '0;
         ie        <= 1'b0;
         idx       <= '0;
         int_req   <= 1'b0;
         int_vec   <= '0;
         int_lines <= '0;
      end else begin
         state     <= state_nxt;
         s1        <= irq;
         s2        <= s1;
         s3        <= s2;
         if (mask_load)
            mask <= data[NUM_INT-1:0];
         // A fresh edge on the line being acknowledged keeps it pending.
         pending   <= (pending & ~clr) | rise;
         ie        <= ie_nxt;
         idx       <= idx_nxt;
         int_req   <= req_nxt;
         int_vec   <= vec_nxt;
         int_lines <= lines_nxt;
      end
   end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios plus random traffic,
// all compared against a cycle-accurate behavioural model.
module tb_int_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] irq = '0;
   logic [7:0] data = '0;
   logic       mask_load = 1'b0, ei = 1'b0, di = 1'b0;
   logic       inst_boundary = 1'b0, int_ack = 1'b0, int_done = 1'b0;
   logic       int_req, in_service;
   logic [7:0] int_vec;
   logic [4:0] int_lines, pending;

   int checks = 0;
   int passes = 0;

   int_controller #(.NUM_INT(5), .VEC_BASE(8'hF8)) dut (
      .clk(clk), .rst(rst), .irq(irq), .data(data), .mask_load(mask_load),
      .ei(ei), .di(di), .inst_boundary(inst_boundary), .int_ack(int_ack),
      .int_done(int_done), .int_req(int_req), .int_vec(int_vec),
      .int_lines(int_lines), .pending(pending), .in_service(in_service)
   );

   always #5 clk = ~clk;

   // Behavioural model: irq sample history, pending set, enable, mask and mode
   // (0 = idle, 1 = awaiting ack, 2 = servicing) with the granted line number.
   bit [4:0] h [3];
   bit [4:0] m_pend = '0, m_mask = '0;
   bit       m_ie = 1'b0;
   int       m_mode = 0;
   int       m_idx = 0;

   function automatic bit [19:0] expv();
      bit [7:0] v;
      bit [4:0] l;
      v = (m_mode == 0) ? 8'h00 : 8'(248 + m_idx);
      l = (m_mode == 0) ? 5'd0 : 5'(1 << m_idx);
      return {m_mode == 1, v, l, m_pend, m_mode == 2};
   endfunction

   function automatic bit [19:0] obs();
      return {int_req, int_vec, int_lines, pending, in_service};
   endfunction

   task automatic tick();
      bit [4:0] rise, clr;
      bit       ie_n;
      int       w;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 3; i++) h[i] = '0;
         m_pend = '0; m_mask = '0; m_ie = 1'b0; m_mode = 0; m_idx = 0;
      end else begin
         rise = h[1] & ~h[2];
         clr  = '0;
         ie_n = di ? 1'b0 : (ei ? 1'b1 : m_ie);
         if (m_mode == 0) begin
            if (inst_boundary && m_ie) begin
               w = -1;
               for (int i = 0; i < 5; i++)
                  if (w < 0 && m_pend[i] && m_mask[i]) w = i;
               if (w >= 0) begin m_mode = 1; m_idx = w; end
            end
         end else if (m_mode == 1) begin
            if (int_ack) begin clr[m_idx] = 1'b1; ie_n = 1'b0; m_mode = 2; end
         end else begin
            if (int_done) begin ie_n = 1'b1; m_mode = 0; end
         end
         m_pend = (m_pend & ~clr) | rise;
         m_ie   = ie_n;
         if (mask_load) m_mask = data[4:0];
         h[2] = h[1]; h[1] = h[0]; h[0] = irq;
      end
      #1;
   endtask

   task automatic pulse(input int line);
      irq[line] = 1'b1; tick(); irq = '0; tick(); tick(); tick();
   endtask
   task automatic bnd();      inst_boundary = 1'b1; tick(); inst_boundary = 1'b0; endtask
   task automatic ack();      int_ack = 1'b1;       tick(); int_ack = 1'b0;       endtask
   task automatic done();     int_done = 1'b1;      tick(); int_done = 1'b0;      endtask
   task automatic set_mask(input logic [4:0] m);
      data = {3'b000, m}; mask_load = 1'b1; tick(); mask_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; tick(); tick();
      checks++; if (obs() !== 20'h0) $display("FAIL reset_outputs: got %h expected %h", obs(), 20'h0); else passes++;
      checks++; if (obs() !== expv()) $display("FAIL reset_model: got %h expected %h", obs(), expv()); else passes++;
      rst = 1'b1; tick();
   endtask

   task automatic test_basic_grant();
      set_mask(5'h1F);
      ei = 1'b1; tick(); ei = 1'b0;
      irq[2] = 1'b1; tick(); irq = '0; tick();
      checks++; if (pending !== 5'b00000) $display("FAIL pend_before_k2: got %b expected %b", pending, 5'b00000); else passes++;
      tick();
      checks++; if (pending !== 5'b00100) $display("FAIL pend_at_k2: got %b expected %b", pending, 5'b00100); else passes++;
      tick(); bnd();
      checks++; if ({int_req, int_vec, int_lines} !== {1'b1, 8'hFA, 5'b00100})
         $display("FAIL basic_grant: got %h expected %h", {int_req, int_vec, int_lines}, {1'b1, 8'hFA, 5'b00100}); else passes++;
      ack();
      checks++; if ({pending, int_req, in_service, int_vec} !== {5'b0, 1'b0, 1'b1, 8'hFA})
         $display("FAIL basic_ack: got %h expected %h", {pending, int_req, in_service, int_vec}, {5'b0, 1'b0, 1'b1, 8'hFA}); else passes++;
      done();
      checks++; if (obs() !== 20'h0) $display("FAIL basic_done: got %h expected %h", obs(), 20'h0); else passes++;
      pulse(0); bnd();
      checks++; if (obs() !== expv() || int_vec !== 8'hF8) $display("FAIL ie_after_done: got %h expected %h", obs(), expv()); else passes++;
      ack(); done();
   endtask

   task automatic test_priority();
      irq = 5'b10010; tick(); irq = '0; tick(); tick(); tick();
      bnd();
      checks++; if (int_vec !== 8'hF9) $display("FAIL prio_first: got %h expected %h", int_vec, 8'hF9); else passes++;
      ack(); done(); bnd();
      checks++; if (int_vec !== 8'hFC || int_lines !== 5'b10000) $display("FAIL prio_second: got %h expected %h", int_vec, 8'hFC); else passes++;
      checks++; if (obs() !== expv()) $display("FAIL prio_model: got %h expected %h", obs(), expv()); else passes++;
      ack(); done();
   endtask

   task automatic test_mask_enable();
      set_mask(5'b11110);
      pulse(0); bnd();
      checks++; if (int_req !== 1'b0 || pending[0] !== 1'b1) $display("FAIL masked: got req=%b pend=%b expected req=0 pend0=1", int_req, pending); else passes++;
      set_mask(5'h1F); bnd();
      checks++; if (int_vec !== 8'hF8 || int_req !== 1'b1) $display("FAIL unmasked: got %h expected %h", int_vec, 8'hF8); else passes++;
      ack(); done();
      di = 1'b1; tick(); di = 1'b0;
      pulse(1); bnd();
      checks++; if (int_req !== 1'b0) $display("FAIL ie_off: got %b expected %b", int_req, 1'b0); else passes++;
      ei = 1'b1; di = 1'b1; tick(); ei = 1'b0; di = 1'b0;
      bnd();
      checks++; if (int_req !== 1'b0 || pending !== 5'b00010) $display("FAIL ei_di_both: got req=%b pend=%b expected req=0 pend=00010", int_req, pending); else passes++;
      ei = 1'b1; tick(); ei = 1'b0; bnd();
      checks++; if (int_vec !== 8'hF9) $display("FAIL ei_grant: got %h expected %h", int_vec, 8'hF9); else passes++;
      ack(); done();
   endtask

   task automatic test_no_nesting();
      pulse(2); bnd(); ack();
      pulse(0); bnd(); bnd();
      checks++; if (int_req !== 1'b0 || pending[0] !== 1'b1 || in_service !== 1'b1)
         $display("FAIL no_nest: got req=%b pend=%b svc=%b expected req=0 pend0=1 svc=1", int_req, pending, in_service); else passes++;
      done(); bnd();
      checks++; if (int_vec !== 8'hF8 || int_req !== 1'b1) $display("FAIL after_nest: got %h expected %h", int_vec, 8'hF8); else passes++;
      ack(); done();
   endtask

   task automatic test_collision();
      pulse(3); bnd();
      irq[3] = 1'b1; tick(); irq = '0; tick();
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      checks++; if (pending[3] !== 1'b1 || in_service !== 1'b1) $display("FAIL collision: got pend=%b svc=%b expected pend3=1 svc=1", pending, in_service); else passes++;
      done();
      ack();
      checks++; if (obs() !== {1'b0, 8'h00, 5'b0, 5'b01000, 1'b0}) $display("FAIL stray_ack: got %h expected %h", obs(), {1'b0, 8'h00, 5'b0, 5'b01000, 1'b0}); else passes++;
      bnd(); done();
      checks++; if ({int_req, int_vec, in_service} !== {1'b1, 8'hFB, 1'b0}) $display("FAIL stray_done: got %h expected %h", {int_req, int_vec, in_service}, {1'b1, 8'hFB, 1'b0}); else passes++;
      ack(); done();
   endtask

   task automatic test_reset_mid();
      irq = 5'b01010; tick(); irq = '0; tick(); tick(); tick();
      bnd();
      checks++; if (pending !== 5'b01010 || int_vec !== 8'hF9) $display("FAIL mid_setup: got pend=%b vec=%h expected 01010 f9", pending, int_vec); else passes++;
      rst = 1'b0; tick();
      checks++; if (obs() !== 20'h0) $display("FAIL mid_reset: got %h expected %h", obs(), 20'h0); else passes++;
      rst = 1'b1; tick();
      ei = 1'b1; tick(); ei = 1'b0;
      pulse(0); bnd();
      checks++; if (int_req !== 1'b0 || pending !== 5'b00001) $display("FAIL mask_cleared: got req=%b pend=%b expected req=0 pend=00001", int_req, pending); else passes++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         rst           = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 3) == 0) irq = 5'($urandom);
         data          = 8'($urandom);
         mask_load     = ($urandom_range(0, 9) == 0);
         ei            = ($urandom_range(0, 5) == 0);
         di            = ($urandom_range(0, 11) == 0);
         inst_boundary = ($urandom_range(0, 3) == 0);
         int_ack       = ($urandom_range(0, 2) == 0);
         int_done      = ($urandom_range(0, 3) == 0);
         tick();
         checks++; if (obs() !== expv()) $display("FAIL random_%0d: got %h expected %h", n, obs(), expv()); else passes++;
      end
      {irq, mask_load, ei, di, inst_boundary, int_ack, int_done} = '0;
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 3; i++) h[i] = '0;
      #1;
      test_reset();
      test_basic_grant();
      test_priority();
      test_mask_enable();
      test_no_nesting();
      test_collision();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
